ip_hdr_patch: RTL and testbench
===============================

# ip_hdr_patch

Patches the 20-byte IPv4 header in the header buffer once the UDP header length has been written. On a rising edge of `i_trig` (normally the UDP stage's ready), the block computes the IPv4 total length from the packet-buffer pointers and writes it to header bytes 2–3. It then reads the whole header back, computes the one's-complement header checksum and writes it to bytes 10–11. It sits directly downstream of the UDP length stage and upstream of frame transmit, which waits for `o_ready`.

## Interface
- `ADDR_WIDTH`, 11 — packet-buffer address width.
- `EXTRA_LEN`, 30 — constant added to the payload span: 20 (IP header) + 8 (UDP header) + 2 (payload prefix).
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_trig`  in  1  start request; only a rising edge is acted on.
- `i_data_st`  in  ADDR_WIDTH  payload start address in the packet buffer.
- `i_next_data_st`  in  ADDR_WIDTH  address following the payload end.
- `o_iph_addr`  out  5  header-buffer byte address, used for both read and write.
- `o_iph_rd_en`  out  1  read strobe; data returns on `i_iph_rdata` one cycle later.
- `i_iph_rdata`  in  8  header-buffer read data.
- `o_iph_wdata`  out  8  write data.
- `o_iph_wr_en`  out  1  write strobe; one byte per cycle.
- `o_ready`  out  1  header complete; held high until the next trigger edge.

## Operation
- Reset values: `o_ready`=0, `o_iph_rd_en`=0, `o_iph_wr_en`=0, `o_iph_addr`=0, `o_iph_wdata`=0, state=IDLE, accumulator=0, previous-trigger register=0.
- Edge detection: the previous value of `i_trig` is registered every cycle. A start occurs when `i_trig`=1, the registered value is 0, and state=IDLE. Edges in any other state are ignored and are not queued.
- IDLE: outputs idle. On a start, `o_ready`<=0 and the next state is LEN.
- LEN (1 cycle):
  - span = (`i_next_data_st` − `i_data_st`) mod 2^ADDR_WIDTH, zero-extended to 16 bits.
  - total_len = span + EXTRA_LEN, 16-bit, latched.
  - Clear the 18-bit accumulator.
- READ (20 cycles): `o_iph_rd_en`=1 and `o_iph_addr`=0..19, one per cycle.
- Accumulation: each returned byte (cycle after its address) enters a 16-bit word.
  - Even address = high byte, odd address = low byte.
  - Bytes 2/3 are replaced by total_len[15:8]/[7:0].
  - Bytes 10/11 are replaced by 0.
  - Each completed word is added to the accumulator.
- DRAIN (1 cycle): accumulate the final byte (address 19).
- FOLD (1 cycle): acc = acc[15:0] + acc[17:16].
- FIN (1 cycle): sum = acc[15:0] + acc[16]; checksum = ~sum, 16 bits.
- WRITE (4 cycles): `o_iph_wr_en`=1 with (addr, data) = (2, len[15:8]), (3, len[7:0]), (10, ck[15:8]), (11, ck[7:0]), in that order.
- Exit from WRITE: `o_ready`<=1, state<=IDLE.
- `o_iph_rd_en` and `o_iph_wr_en` are never high in the same cycle.
- Reset mid-operation: all outputs return to their reset values immediately. A partially written header is not restored. No further writes occur until a new trigger edge.

## Timing
- Cycle 0 = the first cycle in LEN, i.e. after the clock edge that sampled the start.
- Cycle 0: LEN.
- Cycles 1–20: READ, addresses 0–19.
- Read data valid in cycles 2–21. Cycle 21 is DRAIN.
- Cycle 22: FOLD. Cycle 23: FIN.
- Cycles 24–27: WRITE.
- `o_ready` is high from cycle 28 onward.
- Total latency: 28 cycles from the first LEN cycle to `o_ready`. The block is busy for 28 cycles, during which `i_trig` is ignored.
- Back-to-back operation: `i_trig` must go low for ≥1 cycle before a new edge is recognised. `o_ready` falls in the cycle after the new start edge is sampled.
- Pointer inputs are sampled only in LEN and need not be held afterward.

## Test plan
- **Basic length:** `i_data_st`=100, `i_next_data_st`=200, header all zeros.
  - Writes: 2←0x00, 3←0x82 (total_len 130).
  - Checksum 0xFF7D: 10←0xFF, 11←0x7D.
  - `o_ready` high 28 cycles after LEN.
- **Pointer wrap-around** (ADDR_WIDTH=11): `i_data_st`=2040, `i_next_data_st`=10.
  - span 18, total_len 48: byte 2←0x00, byte 3←0x30.
- **Known checksum:** header `4500 xxxx 0000 4000 4011 yyyy c0a8 0001 c0a8 00c7`, where xxxx/yyyy are garbage (e.g. FFFF/1234), with span 85.
  - total_len 0x0073; checksum written 0xB861.
  - Proves bytes 2/3/10/11 of the header are ignored on read.
- **Carry folding:** header bytes all 0xFF, span chosen so total_len = 0xFFFF.
  - Accumulator carries fold correctly; checksum 0x0000.
- **Trigger handling:**
  - `i_trig` held high for 50 cycles → exactly one operation.
  - Second edge at cycle 10 of busy → ignored.
  - Edge after `o_ready` → `o_ready` drops next cycle and the sequence repeats.
- **Reset mid-operation:** assert `i_rst_n`=0 during WRITE cycle 25.
  - All outputs return to 0 at once; no further writes; `o_ready` stays 0 until a new complete operation finishes.

Source files
------------

// File: rtl/ip_hdr_patch.sv
// IPv4 header patcher: fills in total length, then reads the 20-byte header back
// and writes the one's-complement header checksum into bytes 10-11.
module ip_hdr_patch #(
  parameter int ADDR_WIDTH = 11,
  parameter int EXTRA_LEN  = 30
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_trig,
  input  logic [ADDR_WIDTH-1:0] i_data_st,
  input  logic [ADDR_WIDTH-1:0] i_next_data_st,
  output logic [4:0]            o_iph_addr,
  output logic                  o_iph_rd_en,
  input  logic [7:0]            i_iph_rdata,
  output logic [7:0]            o_iph_wdata,
  output logic                  o_iph_wr_en,
  output logic                  o_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_READ, S_DRAIN, S_FOLD, S_FIN, S_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic              trig_prev_q, trig_prev_d;
  logic [15:0]       len_q, len_d;
  logic [17:0]       acc_q, acc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       ck_q, ck_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vld_p1_q, vld_p1_d;
  logic [4:0]        raddr_p1_q, raddr_p1_d;
  logic              ready_q, ready_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] span;
  logic [15:0]           total_len;
  logic [7:0]            rbyte;
  logic [15:0]           sum;

  assign span      = i_next_data_st - i_data_st;
  assign total_len = 16'(span) + 16'(EXTRA_LEN);

  // End-around carry is folded on every add so 18 bits never overflow.
  function automatic logic [17:0] acc_add(input logic [17:0] acc, input logic [15:0] w);
    return {2'b00, acc[15:0]} + {16'd0, acc[17:16]} + {2'b00, w};
  endfunction

  function automatic logic [7:0] sub_byte(input logic [4:0] a, input logic [7:0] d,
                                          input logic [15:0] len);
    case (a)
      5'd2:        return len[15:8];
      5'd3:        return len[7:0];
      5'd10, 5'd11: return 8'h00;
      default:     return d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    trig_prev_d = i_trig;
    len_d       = len_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    ck_d        = ck_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vld_p1_d    = rd_en_q;
    raddr_p1_d  = addr_q;
    rbyte       = sub_byte(raddr_p1_q, i_iph_rdata, len_q);
    sum         = acc_q[15:0] + {15'd0, acc_q[16]};

    // Read data returns one cycle after its strobe; pair bytes into words.
    if (vld_p1_q) begin
      if (!raddr_p1_q[0]) hi_d = rbyte;
      else                acc_d = acc_add(acc_q, {hi_q, rbyte});
    end

    case (state_q)
      S_IDLE: begin
        if (i_trig && !trig_prev_q) begin
          ready_d = 1'b0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        len_d   = total_len;
        acc_d   = '0;
        rd_en_d = 1'b1;
        addr_d  = 5'd0;
        state_d = S_READ;
      end
      S_READ: begin
        if (addr_q == 5'd19) begin
          addr_d  = 5'd0;
          state_d = S_DRAIN;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 5'd1;
        end
      end
      S_DRAIN: state_d = S_FOLD;
      S_FOLD: begin
        acc_d   = {2'b00, acc_q[15:0]} + {16'd0, acc_q[17:16]};
        state_d = S_FIN;
      end
      S_FIN: begin
        ck_d    = ~sum;
        wr_en_d = 1'b1;
        addr_d  = 5'd2;
        wdata_d = len_q[15:8];
        cnt_d   = 2'd0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin wr_en_d = 1'b1; addr_d = 5'd3;  wdata_d = len_q[7:0];  end
          2'd1: begin wr_en_d = 1'b1; addr_d = 5'd10; wdata_d = ck_q[15:8]; end
          2'd2: begin wr_en_d = 1'b1; addr_d = 5'd11; wdata_d = ck_q[7:0];  end
          default: begin
            addr_d  = 5'd0;
            wdata_d = 8'h00;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      len_q       <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      ck_q        <= '0;
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      raddr_p1_q  <= '0;
      ready_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      ck_q        <= ck_d;
      cnt_q       <= cnt_d;
      vld_p1_q    <= vld_p1_d;
      raddr_p1_q  <= raddr_p1_d;
      ready_q     <= ready_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_iph_addr  = addr_q;
  assign o_iph_rd_en = rd_en_q;
  assign o_iph_wdata = wdata_q;
  assign o_iph_wr_en = wr_en_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_ip_hdr_patch.sv
// Directed bench for ip_hdr_patch: an 11-bit-pointer instance for most cases and a
// 16-bit-pointer instance that can reach total_len 0xFFFF for the carry case.
module tb_ip_hdr_patch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [10:0] dst_a, nds_a;
  logic [15:0] dst_b, nds_b;
  logic [4:0]  addr_a, addr_b;
  logic        rd_a, rd_b, wr_a, wr_b, rdy_a, rdy_b;
  logic [7:0]  rdat_a, rdat_b, wd_a, wd_b;

  logic [7:0]  mem_a [32];
  logic [7:0]  mem_b [32];
  logic [7:0]  img_a [32];
  logic [7:0]  img_b [32];
  logic        ld;
  logic [4:0]  wl_addr_a [256];
  logic [7:0]  wl_data_a [256];
  logic [7:0]  wl_data_b [256];
  int          wcnt_a = 0;
  int          wcnt_b = 0;
  int          rcnt_a = 0;
  logic        both_seen = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ip_hdr_patch #(.ADDR_WIDTH(11), .EXTRA_LEN(30)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig),
    .i_data_st(dst_a), .i_next_data_st(nds_a),
    .o_iph_addr(addr_a), .o_iph_rd_en(rd_a), .i_iph_rdata(rdat_a),
    .o_iph_wdata(wd_a), .o_iph_wr_en(wr_a), .o_ready(rdy_a)
  );

  ip_hdr_patch #(.ADDR_WIDTH(16), .EXTRA_LEN(30)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig),
    .i_data_st(dst_b), .i_next_data_st(nds_b),
    .o_iph_addr(addr_b), .o_iph_rd_en(rd_b), .i_iph_rdata(rdat_b),
    .o_iph_wdata(wd_b), .o_iph_wr_en(wr_b), .o_ready(rdy_b)
  );

  // Header-buffer models with write logging.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= img_a[i];
        mem_b[i] <= img_b[i];
      end
    end else begin
      if (rd_a) begin rdat_a <= mem_a[addr_a]; rcnt_a <= rcnt_a + 1; end
      if (wr_a) begin
        mem_a[addr_a]     <= wd_a;
        wl_addr_a[wcnt_a] <= addr_a;
        wl_data_a[wcnt_a] <= wd_a;
        wcnt_a            <= wcnt_a + 1;
      end
      if (rd_b) rdat_b <= mem_b[addr_b];
      if (wr_b) begin
        mem_b[addr_b]     <= wd_b;
        wl_data_b[wcnt_b] <= wd_b;
        wcnt_b            <= wcnt_b + 1;
      end
    end
    if ((rd_a && wr_a) || (rd_b && wr_b)) both_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int base, input logic [31:0] exp_d);
    check_eq({tag, "_nwr"}, 32'(wcnt_a - base), 32'd4);
    check_eq({tag, "_addr"},
             {12'd0, wl_addr_a[base], wl_addr_a[base+1], wl_addr_a[base+2], wl_addr_a[base+3]},
             {12'd0, 5'd2, 5'd3, 5'd10, 5'd11});
    check_eq({tag, "_data"},
             {wl_data_a[base], wl_data_a[base+1], wl_data_a[base+2], wl_data_a[base+3]}, exp_d);
  endtask

  task automatic load_mem();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  // Raise trig, keep it high for hold_cyc cycles; lat counts cycles from LEN to o_ready.
  task automatic run_op(input int hold_cyc, output int lat, output logic rdy0);
    @(negedge clk); trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy0 = rdy_a;
    lat  = 0;
    while (!rdy_a && lat < 60) begin
      if (lat + 1 >= hold_cyc) trig = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   lat, wb, wbb, rb;
  logic r0;

  initial begin
    rst_n = 1'b0; trig = 1'b0; ld = 1'b0;
    dst_a = '0; nds_a = '0; dst_b = 16'd0; nds_b = 16'hFFE1;
    for (int i = 0; i < 32; i++) begin img_a[i] = 8'h00; img_b[i] = 8'hFF; end
    load_mem();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {16'd0, rdy_a, rd_a, wr_a, addr_a, wd_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_outs", {16'd0, rdy_a, rd_a, wr_a, addr_a, wd_a}, 32'd0);

    // Basic length on a zero header; instance B runs the all-0xFF carry case.
    dst_a = 11'd100; nds_a = 11'd200;
    wb = wcnt_a; rb = rcnt_a; wbb = wcnt_b;
    run_op(1, lat, r0);
    check_eq("basic_lat", 32'(lat), 32'd28);
    check_eq("basic_nrd", 32'(rcnt_a - rb), 32'd20);
    check_writes("basic", wb, 32'h0082FF7D);
    check_eq("carry_nwr", 32'(wcnt_b - wbb), 32'd4);
    check_eq("carry_data", {wl_data_b[wbb], wl_data_b[wbb+1], wl_data_b[wbb+2], wl_data_b[wbb+3]},
             32'hFFFF0000);
    repeat (3) @(negedge clk);

    // Pointer wrap-around.
    dst_a = 11'd2040; nds_a = 11'd10;
    wb = wcnt_a;
    run_op(1, lat, r0);
    check_eq("wrap_lat", 32'(lat), 32'd28);
    check_writes("wrap", wb, 32'h0030FFCF);
    repeat (3) @(negedge clk);

    // Known header with garbage in the length and checksum fields.
    begin
      logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                               8'h12, 8'h34, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
      for (int i = 0; i < 20; i++) img_a[i] = hdr[i];
    end
    load_mem();
    dst_a = 11'd0; nds_a = 11'd85;
    wb = wcnt_a;
    run_op(1, lat, r0);
    check_writes("known", wb, 32'h0073B861);
    check_eq("known_mem", {16'd0, mem_a[10], mem_a[11]}, 32'h0000B861);
    repeat (3) @(negedge clk);

    // Trigger held high for 50 cycles: one operation only.
    wb = wcnt_a;
    run_op(50, lat, r0);
    check_eq("hold_lat", 32'(lat), 32'd28);
    repeat (22) @(negedge clk);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("hold_nwr", 32'(wcnt_a - wb), 32'd4);
    check_eq("hold_rdy", {31'd0, rdy_a}, 32'd1);

    // Second edge at busy cycle 10 is ignored.
    wb = wcnt_a;
    trig = 1'b1;
    @(posedge clk);
    @(negedge clk); trig = 1'b0;
    repeat (10) @(negedge clk);
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    lat = 11;
    while (!rdy_a && lat < 60) begin @(negedge clk); lat++; end
    check_eq("busy_edge_lat", 32'(lat), 32'd28);
    repeat (40) @(negedge clk);
    check_eq("busy_edge_nwr", 32'(wcnt_a - wb), 32'd4);

    // Edge after o_ready: ready drops next cycle and the sequence repeats.
    check_eq("rearm_pre_rdy", {31'd0, rdy_a}, 32'd1);
    wb = wcnt_a;
    run_op(1, lat, r0);
    check_eq("rearm_rdy_drop", {31'd0, r0}, 32'd0);
    check_eq("rearm_lat", 32'(lat), 32'd28);
    check_writes("rearm", wb, 32'h0073B861);
    repeat (3) @(negedge clk);

    // Reset during WRITE cycle 25.
    wb = wcnt_a;
    trig = 1'b1;
    @(posedge clk);
    @(negedge clk); trig = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("midrst_in_write", {26'd0, wr_a, addr_a}, {26'd0, 1'b1, 5'd3});
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {16'd0, rdy_a, rd_a, wr_a, addr_a, wd_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("midrst_nwr", 32'(wcnt_a - wb), 32'd1);
    check_eq("midrst_rdy", {31'd0, rdy_a}, 32'd0);
    wb = wcnt_a;
    run_op(1, lat, r0);
    check_eq("post_rst_lat", 32'(lat), 32'd28);
    check_writes("post_rst", wb, 32'h0073B861);

    check_eq("rd_wr_overlap", {31'd0, both_seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
